// File: rtl/sobel_pkg.sv
// ============================================================================
// Module : sobel_pkg
// Brief  : Shared types and constants for the Sobel frame sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sobel_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_INIT       = 4'd1,
        S_FETCH      = 4'd2,
        S_COMPUTE    = 4'd3,
        S_WAIT_SOBEL = 4'd4,
        S_WRITE      = 4'd5,
        S_MOVE       = 4'd6,
        S_WAIT_MOVE  = 4'd7,
        S_DONE       = 4'd8
    } seq_state_t;

    localparam int WIN_PIXELS  = 9;
    localparam int SLOT_FIRST  = 0;
    localparam int SLOT_CENTER = 4;
    localparam int SLOT_LAST   = WIN_PIXELS - 1;

endpackage

`default_nettype wire

// File: rtl/window_addr_gen.sv
// ============================================================================
// Module : window_addr_gen
// Brief  : Walks pixel index k over the 3x3 window and forms its read address.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module window_addr_gen
    import sobel_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DIM_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_advance,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [DIM_W-1:0]  i_width,
    output logic [ADDR_W-1:0] o_addr,
    output logic [3:0]        o_k,
    output logic              o_last
);

    localparam int SUM_W = (DIM_W > ADDR_W) ? DIM_W : ADDR_W;

    logic [3:0]        r_k;
    logic [1:0]        r_col;
    logic [ADDR_W-1:0] r_row_base;

    // Row base accumulates the pitch modulo 2^ADDR_W, matching address wrap.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_k        <= 4'd0;
            r_col      <= 2'd0;
            r_row_base <= '0;
        end else if (i_advance) begin
            r_k <= r_k + 4'd1;
            if (r_col == 2'd2) begin
                r_col      <= 2'd0;
                r_row_base <= ADDR_W'(SUM_W'(r_row_base) + SUM_W'(i_width));
            end else begin
                r_col <= r_col + 2'd1;
            end
        end
    end

    assign o_addr = i_base + r_row_base + ADDR_W'(r_col);
    assign o_k    = r_k;
    assign o_last = (r_k == 4'(SLOT_LAST));

endmodule

`default_nettype wire

// File: rtl/sobel_frame_sequencer.sv
// ============================================================================
// Module : sobel_frame_sequencer
// Brief  : Fetches each 3x3 window, runs Sobel, writes result, steps the window.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sobel_frame_sequencer
    import sobel_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DIM_W  = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_start,
    input  logic [DIM_W-1:0]               width,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           load_initial,
    output logic                           start_move,
    input  logic [ADDR_W-1:0]              addr_r,
    input  logic [ADDR_W-1:0]              addr_w,
    input  logic                           move_done,
    input  logic                           all_done,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    input  logic                           mem_ack,
    output logic                           sobel_start,
    output logic [WIN_PIXELS*DATA_W-1:0]   window,
    input  logic                           sobel_done,
    input  logic [DATA_W-1:0]              sobel_result
);

    seq_state_t                      r_state;
    logic [DIM_W-1:0]                r_width;
    logic [DATA_W-1:0]               r_result;
    logic [WIN_PIXELS*DATA_W-1:0]    r_window;
    logic                            r_busy, r_frame_done, r_load_initial, r_start_move;
    logic                            r_mem_req, r_mem_we, r_sobel_start;
    logic [ADDR_W-1:0]               r_mem_addr;
    logic [DATA_W-1:0]               r_mem_wdata;

    logic [ADDR_W-1:0]               w_fetch_addr;
    logic [3:0]                      w_k;
    logic                            w_last;
    logic                            w_rd_ack;

    assign w_rd_ack = (r_state == S_FETCH) && r_mem_req && mem_ack;

    // Index generator stays cleared outside FETCH so every window starts at k=0.
    window_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (r_state != S_FETCH),
        .i_advance (w_rd_ack),
        .i_base    (addr_r),
        .i_width   (r_width),
        .o_addr    (w_fetch_addr),
        .o_k       (w_k),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_width        <= '0;
            r_result       <= '0;
            r_window       <= '0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_load_initial <= 1'b0;
            r_start_move   <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_sobel_start  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_width        <= width;
                        r_busy         <= 1'b1;
                        r_load_initial <= 1'b1;
                        r_state        <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_load_initial <= 1'b0;
                    r_state        <= S_FETCH;
                end
                S_FETCH: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_fetch_addr;
                    end else if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        for (int s = SLOT_FIRST; s <= SLOT_LAST; s++) begin
                            if (w_k == 4'(s)) begin
                                r_window[s*DATA_W +: DATA_W] <= mem_rdata;
                            end
                        end
                        if (w_last) begin
                            r_sobel_start <= 1'b1;
                            r_state       <= S_COMPUTE;
                        end
                    end
                end
                S_COMPUTE: begin
                    r_sobel_start <= 1'b0;
                    r_state       <= S_WAIT_SOBEL;
                end
                S_WAIT_SOBEL: begin
                    if (sobel_done) begin
                        r_result <= sobel_result;
                        r_state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!r_mem_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= addr_w;
                        r_mem_wdata <= r_result;
                    end else if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (all_done) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_start_move <= 1'b1;
                            r_state      <= S_MOVE;
                        end
                    end
                end
                S_MOVE: begin
                    r_start_move <= 1'b0;
                    r_state      <= S_WAIT_MOVE;
                end
                S_WAIT_MOVE: begin
                    if (move_done) begin
                        if (all_done) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign load_initial = r_load_initial;
    assign start_move   = r_start_move;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign sobel_start  = r_sobel_start;
    assign window       = r_window;

endmodule

`default_nettype wire

// File: tb/tb_sobel_frame_sequencer.sv
// ============================================================================
// Module : tb_sobel_frame_sequencer
// Brief  : Directed/random bench acting as memory, Sobel unit and move_control.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sobel_frame_sequencer;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic [11:0] width;
    logic        busy, frame_done, load_initial, start_move;
    logic [7:0]  addr_r, addr_w;
    logic        move_done, all_done;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        sobel_start;
    logic [71:0] window;
    logic        sobel_done;
    logic [7:0]  sobel_result;

    int errors = 0;
    int checks = 0;

    sobel_frame_sequencer #(.ADDR_W(8), .DATA_W(8), .DIM_W(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .width        (width),
        .busy         (busy),
        .frame_done   (frame_done),
        .load_initial (load_initial),
        .start_move   (start_move),
        .addr_r       (addr_r),
        .addr_w       (addr_w),
        .move_done    (move_done),
        .all_done     (all_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .sobel_start  (sobel_start),
        .window       (window),
        .sobel_done   (sobel_done),
        .sobel_result (sobel_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 72'(busy), 72'd0);
        check({tag, "_frame_done"}, 72'(frame_done), 72'd0);
        check({tag, "_load_initial"}, 72'(load_initial), 72'd0);
        check({tag, "_start_move"}, 72'(start_move), 72'd0);
        check({tag, "_mem_req"}, 72'(mem_req), 72'd0);
        check({tag, "_mem_we"}, 72'(mem_we), 72'd0);
        check({tag, "_mem_addr"}, 72'(mem_addr), 72'd0);
        check({tag, "_mem_wdata"}, 72'(mem_wdata), 72'd0);
        check({tag, "_sobel_start"}, 72'(sobel_start), 72'd0);
        check({tag, "_window"}, window, 72'd0);
    endtask

    // Memory responder for one access: waits for the request, checks it is held, acks.
    task automatic serve(input logic we, input logic [7:0] addr, input logic [7:0] data,
                         input int delay, input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        check({tag, "_req_seen"}, 72'(mem_req), 72'd1);
        for (int i = 0; i <= delay; i++) begin
            check({tag, "_req_hold"}, 72'(mem_req), 72'd1);
            check({tag, "_we"}, 72'(mem_we), 72'(we));
            check({tag, "_addr"}, 72'(mem_addr), 72'(addr));
            if (we) check({tag, "_wdata"}, 72'(mem_wdata), 72'(data));
            if (i < delay) step();
        end
        mem_ack = 1'b1;
        if (!we) mem_rdata = data;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        check({tag, "_req_drop"}, 72'(mem_req), 72'd0);
    endtask

    // Reference: nine reads at base + row*pitch + col modulo 256, window packed by k.
    task automatic run_fetch(input int base, input int pitch, input int dmin, input int dmax,
                             input string tag);
        logic [71:0] exp_win;
        logic [7:0]  d;
        int          a;
        exp_win = '0;
        for (int k = 0; k < 9; k++) begin
            a = (base + (k / 3) * pitch + (k % 3)) % 256;
            d = 8'($urandom);
            exp_win[k*8 +: 8] = d;
            serve(1'b0, 8'(a), d, int'($urandom_range(dmax, dmin)), tag);
        end
        check({tag, "_sobel_start"}, 72'(sobel_start), 72'd1);
        check({tag, "_window"}, window, exp_win);
    endtask

    task automatic start_frame(input int pitch, input int base, input string tag);
        addr_r      = 8'(base);
        width       = 12'(pitch);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check({tag, "_load_init_hi"}, 72'(load_initial), 72'd1);
        check({tag, "_busy_hi"}, 72'(busy), 72'd1);
        step();
        check({tag, "_load_init_lo"}, 72'(load_initial), 72'd0);
    endtask

    task automatic sobel_reply(input logic [7:0] res);
        sobel_done   = 1'b1;
        sobel_result = res;
        step();
        sobel_done   = 1'b0;
    endtask

    logic [7:0] r_res;
    logic [7:0] r_wa;
    int         r_pitch;

    initial begin
        reset = 1'b1; frame_start = 1'b0; width = '0; addr_r = '0; addr_w = '0;
        move_done = 1'b0; all_done = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        sobel_done = 1'b0; sobel_result = '0;
        step();
        step();
        reset = 1'b0;
        check_all_zero("reset");

        // Frame A, position 1: width 5 at address 100, data 1..9 in order.
        start_frame(5, 100, "A");
        begin
            int adr [9] = '{100, 101, 102, 105, 106, 107, 110, 111, 112};
            for (int k = 0; k < 9; k++) serve(1'b0, 8'(adr[k]), 8'(k + 1), 0, "A_rd");
        end
        check("A_sobel_start", 72'(sobel_start), 72'd1);
        check("A_window", window, 72'h090807060504030201);
        sobel_done = 1'b1; sobel_result = 8'h77;   // coincides with the pulse: ignored
        step();
        sobel_done = 1'b0;
        check("A_sobel_start_lo", 72'(sobel_start), 72'd0);
        step();
        step();
        check("A_no_early_write", 72'(mem_req), 72'd0);
        sobel_reply(8'h3C);
        addr_w = 8'd0;
        serve(1'b1, 8'd0, 8'h3C, 0, "A_wr");
        check("A_start_move_hi", 72'(start_move), 72'd1);
        move_done = 1'b1;                          // coincides with the pulse: ignored
        step();
        move_done = 1'b0;
        check("A_start_move_lo", 72'(start_move), 72'd0);
        step();
        step();
        check("A_no_early_fetch", 72'(mem_req), 72'd0);
        check("A_start_move_once", 72'(start_move), 72'd0);

        // Position 2: random base, every ack delayed 3 cycles; last position.
        addr_r    = 8'($urandom);
        move_done = 1'b1;
        step();
        move_done = 1'b0;
        run_fetch(int'(addr_r), 5, 3, 3, "A2");
        step();
        r_res = 8'($urandom);
        sobel_reply(r_res);
        r_wa     = 8'($urandom);
        addr_w   = r_wa;
        all_done = 1'b1;
        serve(1'b1, r_wa, r_res, 3, "A2_wr");
        check("A2_frame_done_hi", 72'(frame_done), 72'd1);
        check("A2_busy_in_done", 72'(busy), 72'd1);
        check("A2_no_start_move", 72'(start_move), 72'd0);
        step();
        all_done = 1'b0;
        check("A2_frame_done_lo", 72'(frame_done), 72'd0);
        check("A2_busy_lo", 72'(busy), 72'd0);

        // Frame B: wrap at the top of the address space, then reset in WAIT_SOBEL.
        start_frame(5, 250, "B");
        run_fetch(250, 5, 0, 0, "B");
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("B_reset");

        // Frame C: random pitch and base, stray ack while idle on the bus, random delays.
        r_pitch = int'($urandom_range(30, 1));
        start_frame(r_pitch, int'($urandom_range(255, 0)), "C");
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        step();
        mem_ack = 1'b0;
        run_fetch(int'(addr_r), r_pitch, 0, 2, "C");
        step();
        r_res = 8'($urandom);
        sobel_reply(r_res);
        r_wa   = 8'($urandom);
        addr_w = r_wa;
        serve(1'b1, r_wa, r_res, int'($urandom_range(2, 0)), "C_wr");
        check("C_start_move_hi", 72'(start_move), 72'd1);
        step();
        all_done  = 1'b1;
        move_done = 1'b1;
        step();
        move_done = 1'b0;
        all_done  = 1'b0;
        check("C_frame_done_hi", 72'(frame_done), 72'd1);
        check("C_no_fetch_after_done", 72'(mem_req), 72'd0);
        step();
        check("C_frame_done_lo", 72'(frame_done), 72'd0);
        check("C_busy_lo", 72'(busy), 72'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sobel_frame_sequencer.md
# sobel_frame_sequencer

Top-level sequencer for one Sobel pass over a frame. It drives `move_control` to walk the 3x3 window across the image. At each position it fetches the nine window pixels over a shared single-port memory bus, hands the window to the Sobel compute unit, and writes the returned pixel to the output address. It then requests the next move, repeating until `move_control` reports `all_done`.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width; matches `move_control` `addr_r`/`addr_w`.
- `DATA_W`, 8: pixel width.
- `DIM_W`, 12: frame width/length field width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `frame_start` in 1: one-cycle pulse; starts a frame when idle.
- `width` in `DIM_W`: row pitch in pixels; sampled at `frame_start`.
- `busy` out 1: high from the cycle after accepted `frame_start` until `frame_done`.
- `frame_done` out 1: one-cycle pulse at end of frame.
- `load_initial` out 1: to `move_control`.
- `start_move` out 1: to `move_control`.
- `addr_r` in `ADDR_W`: from `move_control`; window top-left.
- `addr_w` in `ADDR_W`: from `move_control`; output pixel address.
- `move_done` in 1: from `move_control`.
- `all_done` in 1: from `move_control`.
- `mem_req` out 1: memory request, held until ack.
- `mem_we` out 1: 1 = write, 0 = read; valid with `mem_req`.
- `mem_addr` out `ADDR_W`: request address.
- `mem_wdata` out `DATA_W`: write data.
- `mem_rdata` in `DATA_W`: valid in the `mem_ack` cycle of a read.
- `mem_ack` in 1: one-cycle acknowledge.
- `sobel_start` out 1: one-cycle pulse; window valid.
- `window` out `9*DATA_W`: pixel k at bits [k*DATA_W +: DATA_W]; k = 3*row + col.
- `sobel_done` in 1: result valid.
- `sobel_result` in `DATA_W`: computed pixel.

## Operation
- States: `IDLE`, `INIT`, `FETCH`, `COMPUTE`, `WAIT_SOBEL`, `WRITE`, `MOVE`, `WAIT_MOVE`, `DONE`.
- `IDLE`: `frame_start` latches `width` and goes to `INIT`. `frame_start` is ignored in all other states.
- `INIT`: `load_initial`=1 for exactly one cycle, then `FETCH` with pixel index k=0.
- `FETCH`:
  - Issues a read at `addr_r + (k/3)*width + (k%3)`, truncated to `ADDR_W` (wraps mod 2^ADDR_W).
  - On `mem_ack`, stores `mem_rdata` into window slot k and increments k.
  - After k=8 is acked, goes to `COMPUTE`.
  - Row offset is computed as a running sum (row base += width), not with a multiplier.
- `COMPUTE`: `sobel_start`=1 for one cycle, then `WAIT_SOBEL`.
- `WAIT_SOBEL`: on `sobel_done`, registers `sobel_result` and goes to `WRITE`.
- `WRITE`: write request at `addr_w` with the registered result. On `mem_ack`:
  - if `all_done`=1, go to `DONE`;
  - otherwise go to `MOVE`.
- `MOVE`: `start_move`=1 for one cycle, then `WAIT_MOVE`.
- `WAIT_MOVE`: on `move_done`:
  - if `all_done`=1, go to `DONE`;
  - otherwise go to `FETCH` with k=0.
- `DONE`: `frame_done`=1 for one cycle, then `IDLE`.
- `window` holds its contents until overwritten by the next fetch, so it stays stable through `WAIT_SOBEL`.

## Timing
- Reset values: all outputs 0, `window` 0, state `IDLE`.
- `reset` mid-frame: in the cycle after the reset edge, all outputs are 0 and state is `IDLE`. Any outstanding memory request is dropped.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered and stable from request until the ack cycle.
- `mem_req` drops the cycle after `mem_ack`.
- The next read request is issued in the cycle after an ack, so each read takes at least 2 cycles.
- A `mem_ack` arriving while `mem_req`=0 is ignored.
- Minimum per-position latency with zero-wait memory, compute and move: 18 (fetch) + 1 + 1 + 2 + 1 + 1 = 24 cycles.
- `sobel_done` or `move_done` arriving in the same cycle the pulse is driven is ignored; only the wait states sample them.
- `busy` is high in every state except `IDLE`. `frame_done` and `busy` are both high in `DONE`.

## Structure
- Shared package `sobel_pkg`:
  - state enum `seq_state_t`;
  - `WIN_PIXELS` = 9;
  - `window` slot index constants.
- One sub-module: `window_addr_gen`. It holds k and the row-base accumulator, and outputs the fetch address and the last-pixel flag.
- All other logic lives in the FSM.

## Test plan
- Reset, then `frame_start` with `width`=5 and `addr_r`=100:
  - -> `load_initial` one cycle;
  - -> reads 100, 101, 102, 105, 106, 107, 110, 111, 112 in order;
  - -> `window` slots 0..8 hold the returned data 1..9.
- `sobel_done` with result 0x3C, `addr_w`=0 -> one write: `mem_we`=1, `mem_addr`=0, `mem_wdata`=0x3C; then a single `start_move` pulse.
- Memory ack delayed 3 cycles on every access -> request signals held constant for 4 cycles; addresses unchanged.
- `all_done`=1 at the write ack -> no `start_move`; `frame_done` pulses once; `busy` falls the next cycle.
- `addr_r`=250 with `width`=5 -> row-2 reads wrap to 4, 5, 6.
- `reset` asserted during `WAIT_SOBEL` -> all outputs 0 the next cycle; a following `frame_start` restarts cleanly.
